channel_decimator: RTL
======================

# channel_decimator

Per-channel boxcar decimator placed directly downstream of the 128-tap FIR stage in the sonar receive chain. It consumes the FIR's interleaved four-channel AXI-Stream, where `tuser` carries the channel index. For each channel independently it averages `2^LOG2_DECIM` consecutive samples and emits one result per block, tagged with the same channel index. This reduces the sample rate ahead of the beamforming and envelope stages.

## Interface
Parameters:
- `LOG2_DECIM`, default 4: decimation factor is `2^LOG2_DECIM`; legal range 1..8.
- `ACC_W`, default `32+LOG2_DECIM`: accumulator width per channel; must be at least `32+LOG2_DECIM`.

Ports:
- `s_axis_aclk` in 1: the single clock; all logic is synchronous to its rising edge.
- `s_axis_arst` in 1: synchronous, active-high reset.
- `s_axis_tdata` in 32, signed: filtered sample.
- `s_axis_tvalid` in 1: input valid.
- `s_axis_tready` out 1: input ready.
- `s_axis_tuser` in 2: channel index 0..3.
- `m_axis_tdata` out 32, signed: decimated sample.
- `m_axis_tvalid` out 1: output valid.
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tuser` out 2: channel index of `m_axis_tdata`.

## Operation
- State per channel c (0..3):
  - `acc[c]`, signed, `ACC_W` bits.
  - `cnt[c]`, `LOG2_DECIM` bits.
  - Both are cleared by reset.
- Output holding register: `m_axis_tdata`, `m_axis_tuser`, `m_axis_tvalid`. This is a single-entry buffer.
- An input beat is accepted when `s_axis_tvalid & s_axis_tready`. Let c = `s_axis_tuser`.
- When `cnt[c] != 2^LOG2_DECIM-1` on an accepted beat:
  - `acc[c] <= acc[c] + sext(s_axis_tdata)`.
  - `cnt[c] <= cnt[c]+1`.
- When `cnt[c] == 2^LOG2_DECIM-1` on an accepted beat (block complete):
  - Compute `sum = acc[c] + sext(s_axis_tdata)`.
  - Load `m_axis_tdata <= (sum >>> LOG2_DECIM)[31:0]`. This is an arithmetic shift, so the average always fits in 32 bits and needs no saturation.
  - Load `m_axis_tuser <= c` and `m_axis_tvalid <= 1`.
  - Clear `acc[c] <= 0` and `cnt[c] <= 0`.
- Channels are fully independent. Arbitrary interleaving order is legal; a channel's progress is unaffected by beats on other channels.
- An output beat completes when `m_axis_tvalid & m_axis_tready`. It clears `m_axis_tvalid` unless a new block completes in the same cycle.
- `s_axis_tready = !s_axis_arst & (!m_axis_tvalid | m_axis_tready)`.
  - This is conservative: input stalls whenever the output register is occupied and not draining, even if the incoming beat would not complete a block.
  - This keeps the control path free of combinational paths through `acc` and `cnt`.

## Timing
- Reset values: `m_axis_tdata`=0, `m_axis_tvalid`=0, `m_axis_tuser`=0.
- `s_axis_tready` is 0 while `s_axis_arst`=1, and 1 in the first cycle after reset deasserts.
- Latency: the block-completing input beat accepted at edge N gives `m_axis_tvalid`=1 after edge N.
- Throughput: one input beat per cycle while `m_axis_tready`=1.
- Output held: `m_axis_tdata`, `m_axis_tuser` and `m_axis_tvalid` stay stable while `m_axis_tvalid & !m_axis_tready`.
- Simultaneous output drain and new block completion: the register reloads with the new result and `m_axis_tvalid` stays 1 with no bubble.
- Reset mid-block discards all partial sums and counts. The first post-reset sample on each channel starts a fresh block.
- Counter wrap: `cnt` never exceeds `2^LOG2_DECIM-1`; completion always returns it to 0.

## Configuration
- `CHANNEL_DECIMATOR_ROUND_EN` defined:
  - The result is `(sum + 2^(LOG2_DECIM-1)) >>> LOG2_DECIM`, i.e. round half toward +inf.
  - The addition is done at `ACC_W+1` bits so it cannot overflow.
- Not defined: the result is truncated (floor) as `sum >>> LOG2_DECIM`.
- Default build leaves the macro undefined.

## Test plan
- Reset behaviour, `LOG2_DECIM`=2: assert `s_axis_arst` for 3 cycles -> all outputs 0 and `s_axis_tready`=0; after release `s_axis_tready`=1.
- Single-channel average, ch0, samples 4,8,12,16 -> one output `m_axis_tdata`=10, `m_axis_tuser`=0, exactly 1 cycle after the 4th beat.
- Negative floor vs round, ch1, samples -1,-1,-1,0 (sum -3):
  - Without the macro -> -1.
  - With `CHANNEL_DECIMATOR_ROUND_EN` -> -1 ((-3+2)>>>2).
  - Samples -2,-2,-2,0 (sum -6): without -> -2; with -> -1.
- Interleaved channels, round-robin ch0..ch3 with ch k sending k*100 for 4 rounds -> outputs 0,100,200,300 with tuser 0,1,2,3 in that order.
- Backpressure: hold `m_axis_tready`=0 after the first output -> `s_axis_tready`=0 and `m_axis_tdata` stable for 10 cycles. Then `m_axis_tready`=1 -> the held beat transfers and no samples are lost; the checker's sum matches the reference model.
- Reset mid-block: ch2 receives 1000,1000; reset; then 4,4,4,4 -> the single output is 4, not polluted by the pre-reset samples.

Source files
------------

// File: rtl/channel_decimator.sv
// Per-channel boxcar decimator: averages 2^LOG2_DECIM samples per channel (tuser 0..3), one result per block.
// Latency: result is registered on the edge that accepts the block-completing beat; output valid next cycle.
// Backpressure: single-entry output register; input stalls whenever it holds data that is not draining.
// Optional build macro CHANNEL_DECIMATOR_ROUND_EN: round half toward +inf instead of floor.
module channel_decimator #(
  parameter int LOG2_DECIM = 4,
  parameter int ACC_W      = 32 + LOG2_DECIM
) (
  input  logic               s_axis_aclk,
  input  logic               s_axis_arst,
  input  logic signed [31:0] s_axis_tdata,
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  input  logic [1:0]         s_axis_tuser,
  output logic signed [31:0] m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic [1:0]         m_axis_tuser
);

  localparam logic [LOG2_DECIM-1:0] CNT_LAST = '1;
`ifdef CHANNEL_DECIMATOR_ROUND_EN
  localparam logic signed [ACC_W:0] ROUND_HALF = {{ACC_W{1'b0}}, 1'b1} << (LOG2_DECIM - 1);
`endif

  logic signed [ACC_W-1:0]  acc [4];
  logic [LOG2_DECIM-1:0]    cnt [4];

  logic                     accept;
  logic                     block_done;
  logic signed [ACC_W-1:0]  sample_ext;
  logic signed [ACC_W-1:0]  sum;
  logic signed [ACC_W:0]    sum_wide;
  logic signed [31:0]       avg;

  // Ready only depends on the output register, never on acc/cnt, to keep the control path short.
  assign s_axis_tready = !s_axis_arst && (!m_axis_tvalid || m_axis_tready);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign block_done    = accept && (cnt[s_axis_tuser] == CNT_LAST);

  // Running sum for the addressed channel and the block average derived from it.
  always_comb begin
    sample_ext = {{(ACC_W-32){s_axis_tdata[31]}}, s_axis_tdata};
    sum        = acc[s_axis_tuser] + sample_ext;
    // One extra bit so the rounding offset can never overflow.
    sum_wide   = {sum[ACC_W-1], sum};
`ifdef CHANNEL_DECIMATOR_ROUND_EN
    sum_wide   = sum_wide + ROUND_HALF;
`endif
    // Arithmetic shift of a sum of 2^LOG2_DECIM 32-bit values always fits back in 32 bits.
    avg        = 32'(sum_wide >>> LOG2_DECIM);
  end

  // Per-channel accumulate; the block-completing beat restarts that channel from zero.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_arst) begin
      for (int c = 0; c < 4; c++) begin
        acc[c] <= '0;
        cnt[c] <= '0;
      end
    end else if (accept) begin
      if (block_done) begin
        acc[s_axis_tuser] <= '0;
        cnt[s_axis_tuser] <= '0;
      end else begin
        acc[s_axis_tuser] <= sum;
        cnt[s_axis_tuser] <= cnt[s_axis_tuser] + 1'b1;
      end
    end
  end

  // Output holding register: a new result reloads it even while the old one drains (no bubble).
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_arst) begin
      m_axis_tdata  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tvalid <= 1'b0;
    end else if (block_done) begin
      m_axis_tdata  <= avg;
      m_axis_tuser  <= s_axis_tuser;
      m_axis_tvalid <= 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule
